// File: rtl/ram_arbiter.sv
// Two-requester round-robin front end for the single-port command RAM.
// Each accepted transaction becomes a two-word command sequence on din/rx_valid;
// reads then wait (bounded by TIMEOUT) for tx_valid and return data or an error.
module ram_arbiter #(
  parameter int unsigned ADDR_SIZE = 8,   // payload field must be at least 8 bits wide
  parameter int unsigned TIMEOUT   = 8    // 1..255 cycles spent in the read wait
) (
  input  logic                 clk,
  input  logic                 rst,
  // requester 0
  input  logic                 r0_req,
  input  logic                 r0_we,
  input  logic [ADDR_SIZE-1:0] r0_addr,
  input  logic [7:0]           r0_wdata,
  output logic                 r0_gnt,
  output logic                 r0_done,
  output logic                 r0_err,
  output logic [7:0]           r0_rdata,
  // requester 1
  input  logic                 r1_req,
  input  logic                 r1_we,
  input  logic [ADDR_SIZE-1:0] r1_addr,
  input  logic [7:0]           r1_wdata,
  output logic                 r1_gnt,
  output logic                 r1_done,
  output logic                 r1_err,
  output logic [7:0]           r1_rdata,
  // RAM command / response
  output logic                 rx_valid,
  output logic [ADDR_SIZE+1:0] din,
  input  logic [7:0]           dout,
  input  logic                 tx_valid,
  output logic                 busy
);

  localparam logic [1:0] OpWrAddr = 2'b00;
  localparam logic [1:0] OpWrData = 2'b01;
  localparam logic [1:0] OpRdAddr = 2'b10;
  localparam logic [1:0] OpRdData = 2'b11;

  localparam logic [7:0] TimeoutCnt = TIMEOUT[7:0];

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StWrData,
    StRdCmd,
    StRdWait,
    StResp
  } state_e;

  state_e               state_q;
  logic                 owner_q;   // 0 = r0, 1 = r1
  logic                 last_q;    // id of the most recently granted requester
  logic                 we_q;
  logic [ADDR_SIZE-1:0] addr_q;
  logic [7:0]           wdata_q;
  logic [7:0]           cnt_q;

  logic                 req_any;
  logic                 win;
  logic                 sel_we;
  logic [ADDR_SIZE-1:0] sel_addr;
  logic [7:0]           sel_wdata;
  logic [ADDR_SIZE-1:0] wdata_payload;
  logic [7:0]           cnt_inc;

  // Round-robin pick among the live requests and mux the winner's fields.
  always_comb begin
    req_any = r0_req | r1_req;
    win     = 1'b0;
    if (r0_req && r1_req) begin
      win = ~last_q;
    end else if (r1_req) begin
      win = 1'b1;
    end
    sel_we        = win ? r1_we    : r0_we;
    sel_addr      = win ? r1_addr  : r0_addr;
    sel_wdata     = win ? r1_wdata : r0_wdata;
    wdata_payload = ADDR_SIZE'(wdata_q);
    cnt_inc       = cnt_q + 8'd1;
  end

  // Transaction FSM; every output is a register loaded on the way into its state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      rx_valid <= 1'b0;
      din      <= '0;
      busy     <= 1'b0;
      r0_gnt   <= 1'b0;
      r1_gnt   <= 1'b0;
      r0_done  <= 1'b0;
      r1_done  <= 1'b0;
      r0_err   <= 1'b0;
      r1_err   <= 1'b0;
      r0_rdata <= 8'h00;
      r1_rdata <= 8'h00;
    end else begin
      // Pulses and the command bus default low; states re-assert what they need.
      r0_gnt   <= 1'b0;
      r1_gnt   <= 1'b0;
      r0_done  <= 1'b0;
      r1_done  <= 1'b0;
      r0_err   <= 1'b0;
      r1_err   <= 1'b0;
      rx_valid <= 1'b0;
      din      <= '0;

      unique case (state_q)
        StIdle: begin
          if (req_any) begin
            owner_q  <= win;
            last_q   <= win;
            we_q     <= sel_we;
            addr_q   <= sel_addr;
            wdata_q  <= sel_wdata;
            state_q  <= StAddr;
            busy     <= 1'b1;
            rx_valid <= 1'b1;
            din      <= {(sel_we ? OpWrAddr : OpRdAddr), sel_addr};
            r0_gnt   <= ~win;
            r1_gnt   <= win;
          end
        end

        StAddr: begin
          rx_valid <= 1'b1;
          if (we_q) begin
            state_q <= StWrData;
            din     <= {OpWrData, wdata_payload};
          end else begin
            state_q <= StRdCmd;
            din     <= {OpRdData, {ADDR_SIZE{1'b0}}};
          end
        end

        StWrData: begin
          // Writes always complete cleanly.
          state_q <= StResp;
          r0_done <= ~owner_q;
          r1_done <= owner_q;
        end

        StRdCmd: begin
          cnt_q   <= '0;
          state_q <= StRdWait;
        end

        StRdWait: begin
          cnt_q <= cnt_inc;
          // Data arriving on the timeout cycle still wins over the error.
          if (tx_valid) begin
            state_q <= StResp;
            r0_done <= ~owner_q;
            r1_done <= owner_q;
            if (owner_q) begin
              r1_rdata <= dout;
            end else begin
              r0_rdata <= dout;
            end
          end else if (cnt_inc == TimeoutCnt) begin
            state_q <= StResp;
            r0_done <= ~owner_q;
            r1_done <= owner_q;
            r0_err  <= ~owner_q;
            r1_err  <= owner_q;
            if (owner_q) begin
              r1_rdata <= 8'h00;
            end else begin
              r0_rdata <= 8'h00;
            end
          end
        end

        StResp: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end

        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: a per-cycle vector table followed by a
// hand-driven round-robin sequence with both requesters holding req.
module tb_ram_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       r0_req, r0_we, r1_req, r1_we;
  logic [7:0] r0_addr, r0_wdata, r1_addr, r1_wdata;
  logic       r0_gnt, r0_done, r0_err, r1_gnt, r1_done, r1_err;
  logic [7:0] r0_rdata, r1_rdata;
  logic       rx_valid;
  logic [9:0] din;
  logic [7:0] dout;
  logic       tx_valid;
  logic       busy;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  ram_arbiter #(
    .ADDR_SIZE(8),
    .TIMEOUT  (8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .r0_req  (r0_req),
    .r0_we   (r0_we),
    .r0_addr (r0_addr),
    .r0_wdata(r0_wdata),
    .r0_gnt  (r0_gnt),
    .r0_done (r0_done),
    .r0_err  (r0_err),
    .r0_rdata(r0_rdata),
    .r1_req  (r1_req),
    .r1_we   (r1_we),
    .r1_addr (r1_addr),
    .r1_wdata(r1_wdata),
    .r1_gnt  (r1_gnt),
    .r1_done (r1_done),
    .r1_err  (r1_err),
    .r1_rdata(r1_rdata),
    .rx_valid(rx_valid),
    .din     (din),
    .dout    (dout),
    .tx_valid(tx_valid),
    .busy    (busy)
  );

  // One record per clock: inputs held through the edge, outputs expected after it.
  typedef struct {
    logic       i_rst;
    logic [1:0] i_rq;     // bit0 = r0_req, bit1 = r1_req; both share we/addr/wdata
    logic       i_we;
    logic [7:0] i_addr;
    logic [7:0] i_wdata;
    logic       i_tv;
    logic [7:0] i_dout;
    logic       e_rv;
    logic [9:0] e_din;
    logic [1:0] e_gnt;    // {r1, r0}
    logic [1:0] e_done;
    logic [1:0] e_err;
    logic [7:0] e_rd0;
    logic [7:0] e_rd1;
    logic       e_busy;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst_v, input logic [1:0] rq, input logic we,
                     input logic [7:0] addr, input logic [7:0] wdata,
                     input logic tv, input logic [7:0] dv,
                     input logic rv, input logic [9:0] dn, input logic [1:0] gnt,
                     input logic [1:0] done, input logic [1:0] err,
                     input logic [7:0] rd0, input logic [7:0] rd1, input logic bsy);
    vec_t v;
    v.i_rst = rst_v;  v.i_rq = rq;   v.i_we = we;     v.i_addr = addr;
    v.i_wdata = wdata; v.i_tv = tv;  v.i_dout = dv;
    v.e_rv = rv;      v.e_din = dn;  v.e_gnt = gnt;   v.e_done = done;
    v.e_err = err;    v.e_rd0 = rd0; v.e_rd1 = rd1;   v.e_busy = bsy;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [15:0] act,
                     input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic idle_inputs();
    r0_req = 1'b0; r0_we = 1'b0; r0_addr = 8'h00; r0_wdata = 8'h00;
    r1_req = 1'b0; r1_we = 1'b0; r1_addr = 8'h00; r1_wdata = 8'h00;
    tx_valid = 1'b0; dout = 8'h00;
  endtask

  // Safety net: the test is fixed-length, this only fires if something stalls the sim.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] own_mask;
    logic [7:0] own_addr, own_wdata;
    int         ph, own;

    rst = 1'b1;
    idle_inputs();

    // reset held two cycles
    add(1, 2'b00, 0, 8'h00, 8'h00, 0, 8'h00, 0, 10'h000, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 0);
    add(1, 2'b00, 0, 8'h00, 8'h00, 0, 8'h00, 0, 10'h000, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 0);
    // r0 write A5 -> 3C; spurious tx_valid during WR_DATA
    add(0, 2'b01, 1, 8'h3C, 8'hA5, 0, 8'h00, 1, 10'h03C, 2'b01, 2'b00, 2'b00, 8'h00, 8'h00, 1);
    add(0, 2'b00, 0, 8'h00, 8'h00, 0, 8'h00, 1, 10'h1A5, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 1);
    add(0, 2'b00, 0, 8'h00, 8'h00, 1, 8'h77, 0, 10'h000, 2'b00, 2'b01, 2'b00, 8'h00, 8'h00, 1);
    add(0, 2'b00, 0, 8'h00, 8'h00, 0, 8'h00, 0, 10'h000, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 0);
    // r1 read 3C; tx_valid during RD_CMD ignored, real data one cycle after 0x300
    add(0, 2'b10, 0, 8'h3C, 8'h00, 0, 8'h00, 1, 10'h23C, 2'b10, 2'b00, 2'b00, 8'h00, 8'h00, 1);
    add(0, 2'b00, 0, 8'h00, 8'h00, 0, 8'h00, 1, 10'h300, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 1);
    add(0, 2'b00, 0, 8'h00, 8'h00, 1, 8'h55, 0, 10'h000, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 1);
    add(0, 2'b00, 0, 8'h00, 8'h00, 1, 8'hA5, 0, 10'h000, 2'b00, 2'b10, 2'b00, 8'h00, 8'hA5, 1);
    add(0, 2'b00, 0, 8'h00, 8'h00, 0, 8'h00, 0, 10'h000, 2'b00, 2'b00, 2'b00, 8'h00, 8'hA5, 0);
    // r0 read 01, data on second RD_WAIT cycle
    add(0, 2'b01, 0, 8'h01, 8'h00, 0, 8'h00, 1, 10'h201, 2'b01, 2'b00, 2'b00, 8'h00, 8'hA5, 1);
    add(0, 2'b00, 0, 8'h00, 8'h00, 0, 8'h00, 1, 10'h300, 2'b00, 2'b00, 2'b00, 8'h00, 8'hA5, 1);
    add(0, 2'b00, 0, 8'h00, 8'h00, 0, 8'h00, 0, 10'h000, 2'b00, 2'b00, 2'b00, 8'h00, 8'hA5, 1);
    add(0, 2'b00, 0, 8'h00, 8'h00, 0, 8'h00, 0, 10'h000, 2'b00, 2'b00, 2'b00, 8'h00, 8'hA5, 1);
    add(0, 2'b00, 0, 8'h00, 8'h00, 1, 8'h5A, 0, 10'h000, 2'b00, 2'b01, 2'b00, 8'h5A, 8'hA5, 1);
    add(0, 2'b00, 0, 8'h00, 8'h00, 0, 8'h00, 0, 10'h000, 2'b00, 2'b00, 2'b00, 8'h5A, 8'hA5, 0);
    // r0 read 10, RAM silent: eight RD_WAIT cycles, then done+err with rdata 00
    add(0, 2'b01, 0, 8'h10, 8'h00, 0, 8'h00, 1, 10'h210, 2'b01, 2'b00, 2'b00, 8'h5A, 8'hA5, 1);
    add(0, 2'b00, 0, 8'h00, 8'h00, 0, 8'h00, 1, 10'h300, 2'b00, 2'b00, 2'b00, 8'h5A, 8'hA5, 1);
    for (int k = 0; k < 8; k++)
      add(0, 2'b00, 0, 8'h00, 8'h00, 0, 8'h00, 0, 10'h000, 2'b00, 2'b00, 2'b00, 8'h5A, 8'hA5, 1);
    add(0, 2'b00, 0, 8'h00, 8'h00, 0, 8'h00, 0, 10'h000, 2'b00, 2'b01, 2'b01, 8'h00, 8'hA5, 1);
    add(0, 2'b00, 0, 8'h00, 8'h00, 0, 8'h00, 0, 10'h000, 2'b00, 2'b00, 2'b00, 8'h00, 8'hA5, 0);
    // r1 read 20, data arrives exactly on the timeout cycle: data wins, no err
    add(0, 2'b10, 0, 8'h20, 8'h00, 0, 8'h00, 1, 10'h220, 2'b10, 2'b00, 2'b00, 8'h00, 8'hA5, 1);
    add(0, 2'b00, 0, 8'h00, 8'h00, 0, 8'h00, 1, 10'h300, 2'b00, 2'b00, 2'b00, 8'h00, 8'hA5, 1);
    for (int k = 0; k < 8; k++)
      add(0, 2'b00, 0, 8'h00, 8'h00, 0, 8'h00, 0, 10'h000, 2'b00, 2'b00, 2'b00, 8'h00, 8'hA5, 1);
    add(0, 2'b00, 0, 8'h00, 8'h00, 1, 8'hC3, 0, 10'h000, 2'b00, 2'b10, 2'b00, 8'h00, 8'hC3, 1);
    add(0, 2'b00, 0, 8'h00, 8'h00, 0, 8'h00, 0, 10'h000, 2'b00, 2'b00, 2'b00, 8'h00, 8'hC3, 0);
    // later r0 write 0F -> 55 with tx_valid during ADDR and WR_DATA: never latched
    add(0, 2'b01, 1, 8'h55, 8'h0F, 0, 8'h00, 1, 10'h055, 2'b01, 2'b00, 2'b00, 8'h00, 8'hC3, 1);
    add(0, 2'b00, 0, 8'h00, 8'h00, 1, 8'hEE, 1, 10'h10F, 2'b00, 2'b00, 2'b00, 8'h00, 8'hC3, 1);
    add(0, 2'b00, 0, 8'h00, 8'h00, 1, 8'hEE, 0, 10'h000, 2'b00, 2'b01, 2'b00, 8'h00, 8'hC3, 1);
    add(0, 2'b00, 0, 8'h00, 8'h00, 0, 8'h00, 0, 10'h000, 2'b00, 2'b00, 2'b00, 8'h00, 8'hC3, 0);
    // r0 read 77, reset in RD_WAIT: everything back to reset values, no done
    add(0, 2'b01, 0, 8'h77, 8'h00, 0, 8'h00, 1, 10'h277, 2'b01, 2'b00, 2'b00, 8'h00, 8'hC3, 1);
    add(0, 2'b00, 0, 8'h00, 8'h00, 0, 8'h00, 1, 10'h300, 2'b00, 2'b00, 2'b00, 8'h00, 8'hC3, 1);
    add(0, 2'b00, 0, 8'h00, 8'h00, 0, 8'h00, 0, 10'h000, 2'b00, 2'b00, 2'b00, 8'h00, 8'hC3, 1);
    add(1, 2'b00, 0, 8'h00, 8'h00, 0, 8'h00, 0, 10'h000, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 0);
    add(0, 2'b00, 0, 8'h00, 8'h00, 1, 8'h99, 0, 10'h000, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 0);
    add(0, 2'b00, 0, 8'h00, 8'h00, 0, 8'h00, 0, 10'h000, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 0);

    foreach (vecs[i]) begin
      rst      = vecs[i].i_rst;
      r0_req   = vecs[i].i_rq[0];
      r1_req   = vecs[i].i_rq[1];
      r0_we    = vecs[i].i_we;    r1_we    = vecs[i].i_we;
      r0_addr  = vecs[i].i_addr;  r1_addr  = vecs[i].i_addr;
      r0_wdata = vecs[i].i_wdata; r1_wdata = vecs[i].i_wdata;
      tx_valid = vecs[i].i_tv;
      dout     = vecs[i].i_dout;
      @(posedge clk);
      #1;
      chk("rx_valid", i, 16'(rx_valid), 16'(vecs[i].e_rv));
      chk("din", i, 16'(din), 16'(vecs[i].e_din));
      chk("gnt", i, 16'({r1_gnt, r0_gnt}), 16'(vecs[i].e_gnt));
      chk("done", i, 16'({r1_done, r0_done}), 16'(vecs[i].e_done));
      chk("err", i, 16'({r1_err, r0_err}), 16'(vecs[i].e_err));
      chk("r0_rdata", i, 16'(r0_rdata), 16'(vecs[i].e_rd0));
      chk("r1_rdata", i, 16'(r1_rdata), 16'(vecs[i].e_rd1));
      chk("busy", i, 16'(busy), 16'(vecs[i].e_busy));
    end

    // Both requesters hold write requests; after reset last=1 so r0 wins first.
    // Expected per cycle: ADDR, WR_DATA, RESP, IDLE, owner alternating r0,r1,r0,r1.
    idle_inputs();
    rst = 1'b0;
    r0_req = 1'b1; r0_we = 1'b1; r0_addr = 8'h0A; r0_wdata = 8'h11;
    r1_req = 1'b1; r1_we = 1'b1; r1_addr = 8'h0B; r1_wdata = 8'h22;
    for (int c = 0; c < 16; c++) begin
      @(posedge clk);
      #1;
      ph        = c % 4;
      own       = (c / 4) % 2;
      own_mask  = (own == 1) ? 2'b10 : 2'b01;
      own_addr  = (own == 1) ? 8'h0B : 8'h0A;
      own_wdata = (own == 1) ? 8'h22 : 8'h11;
      chk("rr_gnt", 100 + c, 16'({r1_gnt, r0_gnt}), 16'((ph == 0) ? own_mask : 2'b00));
      chk("rr_done", 100 + c, 16'({r1_done, r0_done}), 16'((ph == 2) ? own_mask : 2'b00));
      chk("rr_busy", 100 + c, 16'(busy), 16'(ph != 3));
      chk("rr_din", 100 + c, 16'(din),
          (ph == 0) ? 16'({2'b00, own_addr}) : (ph == 1) ? 16'({2'b01, own_wdata}) : 16'h0);
    end
    idle_inputs();
    @(posedge clk);
    #1;
    chk("rr_end_busy", 200, 16'(busy), 16'h0);
    chk("rr_end_gnt", 200, 16'({r1_gnt, r0_gnt}), 16'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
